// File: rtl/display_time_keeper_pkg.sv
// Shared definitions for the display time-of-day path: BCD constants,
// prescaler width and small BCD helper functions.
package display_time_keeper_pkg;

  localparam int         TICK_CNT_W = 10;
  localparam logic [7:0] BCD_59     = 8'h59;
  localparam logic [7:0] BCD_ZERO   = 8'h00;

  // Two-digit BCD encoding of a small integer (0..99).
  function automatic logic [7:0] to_bcd(input int value);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(value / 10);
    units = 4'(value % 10);
    return {tens, units};
  endfunction

  // Highest legal hour in BCD for a given hour modulus (12 -> 8'h11, 24 -> 8'h23).
  function automatic logic [7:0] hour_max_bcd(input int hour_max);
    return to_bcd(hour_max - 1);
  endfunction

  // True when both nibbles of a BCD byte are decimal digits.
  function automatic logic digits_valid(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/display_time_keeper_bcd_mod_counter.sv
// Two-digit BCD counter that counts 00..MODULUS-1 and wraps to 00.
// wrap is a combinational carry so a cascade of these settles in one edge.
module bcd_mod_counter
  import display_time_keeper_pkg::*;
#(
  parameter int MODULUS = 60
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       wrap
);

  localparam logic [7:0] LAST = to_bcd(MODULUS - 1);

  logic [7:0] next_val;

  assign wrap = inc && (value == LAST);

  // BCD successor of the current value, including the modulus wrap.
  always_comb begin
    next_val = value;
    if (value == LAST) begin
      next_val = BCD_ZERO;
    end else if (value[3:0] == 4'd9) begin
      next_val = {value[7:4] + 4'd1, 4'd0};
    end else begin
      next_val = {value[7:4], value[3:0] + 4'd1};
    end
  end

  // Digit register: load takes priority over increment.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      value <= BCD_ZERO;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      value <= next_val;
    end
  end

endmodule

// File: rtl/display_time_keeper.sv
// BCD HH:MM:SS time keeper driven by divider ticks, with validated time-set
// and run/pause. Holds the tick prescaler, load check and event strobes.
module display_time_keeper
  import display_time_keeper_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1,
  parameter int HOUR_MAX      = 24
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic       tick,
  input  logic       run,
  input  logic       load_valid,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  output logic       load_ack,
  output logic       load_err,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       sec_pulse,
  output logic       min_pulse,
  output logic       day_pulse
);

  localparam logic [TICK_CNT_W-1:0] PRESC_LAST = TICK_CNT_W'(TICKS_PER_SEC - 1);
  localparam logic [7:0]            HOUR_LAST  = hour_max_bcd(HOUR_MAX);

  logic [TICK_CNT_W-1:0] presc;
  logic                  load_legal;
  logic                  load_take;
  logic                  tick_ok;
  logic                  sec_adv;
  logic                  ss_wrap;
  logic                  mm_wrap;
  logic                  hh_wrap;

  // BCD compares are numeric once both digits are known to be decimal.
  assign load_legal = digits_valid(load_hh) && digits_valid(load_mm) &&
                      digits_valid(load_ss) && (load_ss <= BCD_59) &&
                      (load_mm <= BCD_59) && (load_hh <= HOUR_LAST);
  assign load_take  = load_valid && load_legal;
  // A pending load (legal or not) swallows any tick in the same cycle.
  assign tick_ok    = tick && run && !load_valid;
  assign sec_adv    = tick_ok && (presc == PRESC_LAST);

  // Tick prescaler: restarts on an accepted load, wraps on each second.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (load_take) begin
      presc <= '0;
    end else if (tick_ok) begin
      presc <= sec_adv ? '0 : presc + 1'b1;
    end
  end

  // Event strobes and load handshake, one cycle each.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      sec_pulse <= 1'b0;
      min_pulse <= 1'b0;
      day_pulse <= 1'b0;
      load_ack  <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      sec_pulse <= sec_adv;
      min_pulse <= ss_wrap;
      day_pulse <= hh_wrap;
      load_ack  <= load_take;
      load_err  <= load_valid && !load_legal;
    end
  end

  bcd_mod_counter #(.MODULUS(60)) u_ss (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .inc          (sec_adv),
    .load         (load_take),
    .load_val     (load_ss),
    .value        (ss),
    .wrap         (ss_wrap)
  );

  bcd_mod_counter #(.MODULUS(60)) u_mm (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .inc          (ss_wrap),
    .load         (load_take),
    .load_val     (load_mm),
    .value        (mm),
    .wrap         (mm_wrap)
  );

  bcd_mod_counter #(.MODULUS(HOUR_MAX)) u_hh (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .inc          (mm_wrap),
    .load         (load_take),
    .load_val     (load_hh),
    .value        (hh),
    .wrap         (hh_wrap)
  );

endmodule

// File: tb/tb_display_time_keeper.sv
// Bench for display_time_keeper: three instances (1 tick/s 24h, 4 ticks/s 24h,
// 1 tick/s 12h) share stimulus; a seconds-of-day model predicts each one.
module tb_display_time_keeper;

  localparam int TPS[3] = '{1, 4, 1};
  localparam int HM[3]  = '{24, 24, 12};

  logic       clk;
  logic       reset;
  logic       tick;
  logic       run;
  logic       load_valid;
  logic [7:0] load_hh;
  logic [7:0] load_mm;
  logic [7:0] load_ss;

  logic       ack_o [3];
  logic       err_o [3];
  logic [7:0] hh_o  [3];
  logic [7:0] mm_o  [3];
  logic [7:0] ss_o  [3];
  logic       sec_o [3];
  logic       min_o [3];
  logic       day_o [3];

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  // model state: time as seconds of day, prescaler as an integer
  int   m_t   [3];
  int   m_pre [3];
  logic e_sec [3];
  logic e_min [3];
  logic e_day [3];
  logic e_ack [3];
  logic e_err [3];

  display_time_keeper #(.TICKS_PER_SEC(1), .HOUR_MAX(24)) dut0 (
    .clock_100Mhz(clk), .reset(reset), .tick(tick), .run(run),
    .load_valid(load_valid), .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .load_ack(ack_o[0]), .load_err(err_o[0]), .hh(hh_o[0]), .mm(mm_o[0]), .ss(ss_o[0]),
    .sec_pulse(sec_o[0]), .min_pulse(min_o[0]), .day_pulse(day_o[0]));

  display_time_keeper #(.TICKS_PER_SEC(4), .HOUR_MAX(24)) dut1 (
    .clock_100Mhz(clk), .reset(reset), .tick(tick), .run(run),
    .load_valid(load_valid), .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .load_ack(ack_o[1]), .load_err(err_o[1]), .hh(hh_o[1]), .mm(mm_o[1]), .ss(ss_o[1]),
    .sec_pulse(sec_o[1]), .min_pulse(min_o[1]), .day_pulse(day_o[1]));

  display_time_keeper #(.TICKS_PER_SEC(1), .HOUR_MAX(12)) dut2 (
    .clock_100Mhz(clk), .reset(reset), .tick(tick), .run(run),
    .load_valid(load_valid), .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .load_ack(ack_o[2]), .load_err(err_o[2]), .hh(hh_o[2]), .mm(mm_o[2]), .ss(ss_o[2]),
    .sec_pulse(sec_o[2]), .min_pulse(min_o[2]), .day_pulse(day_o[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int dec(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // Reference model: advance seconds-of-day by the tick/load rules.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        m_t[k] = 0; m_pre[k] = 0;
        e_sec[k] = 0; e_min[k] = 0; e_day[k] = 0; e_ack[k] = 0; e_err[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        bit legal;
        e_sec[k] = 0; e_min[k] = 0; e_day[k] = 0; e_ack[k] = 0; e_err[k] = 0;
        if (load_valid) begin
          legal = (load_hh[7:4] <= 9) && (load_hh[3:0] <= 9) &&
                  (load_mm[7:4] <= 9) && (load_mm[3:0] <= 9) &&
                  (load_ss[7:4] <= 9) && (load_ss[3:0] <= 9) &&
                  (dec(load_hh) < HM[k]) && (dec(load_mm) < 60) && (dec(load_ss) < 60);
          if (legal) begin
            m_t[k]   = dec(load_hh) * 3600 + dec(load_mm) * 60 + dec(load_ss);
            m_pre[k] = 0;
            e_ack[k] = 1;
          end else begin
            e_err[k] = 1;
          end
        end else if (tick && run) begin
          if (m_pre[k] == TPS[k] - 1) begin
            m_pre[k] = 0;
            m_t[k]   = m_t[k] + 1;
            e_sec[k] = 1;
            if (m_t[k] % 60 == 0) e_min[k] = 1;
            if (m_t[k] == HM[k] * 3600) begin
              m_t[k]   = 0;
              e_day[k] = 1;
            end
          end else begin
            m_pre[k] = m_pre[k] + 1;
          end
        end
      end
    end
  end

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 3; k++) begin
        logic [28:0] got;
        logic [28:0] want;
        got  = {hh_o[k], mm_o[k], ss_o[k], sec_o[k], min_o[k], day_o[k], ack_o[k], err_o[k]};
        want = {bcd(m_t[k] / 3600), bcd((m_t[k] / 60) % 60), bcd(m_t[k] % 60),
                e_sec[k], e_min[k], e_day[k], e_ack[k], e_err[k]};
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL model_cmp inst=%0d t=%0t got=%h want=%h", k, $time, got, want);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Apply one cycle of inputs; returns 2 time units after the edge that sampled them.
  task automatic step(input logic t, input logic r, input logic lv,
                      input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    tick = t; run = r; load_valid = lv; load_hh = h; load_mm = m; load_ss = s;
    @(posedge clk);
    #2;
  endtask

  task automatic tk();
    step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic ld(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    step(1'b0, 1'b1, 1'b1, h, m, s);
  endtask

  function automatic logic [31:0] tod(input int k);
    return {8'h00, hh_o[k], mm_o[k], ss_o[k]};
  endfunction

  function automatic logic [31:0] pulses(input int k);
    return {29'd0, sec_o[k], min_o[k], day_o[k]};
  endfunction

  initial begin
    int sec_cnt;
    logic [31:0] acc;
    reset = 1'b0; tick = 1'b0; run = 1'b0; load_valid = 1'b0;
    load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00;
    #1 reset = 1'b1;
    #12 reset = 1'b0;
    cmp_en = 1;
    idle();
    chk("reset_time", tod(0), 32'h0);
    chk("reset_pulses", pulses(0), 32'h0);

    // reset mid-count
    repeat (5) tk();
    chk("five_ticks_ss", tod(0), 32'h000005);
    reset = 1'b1;
    #1;
    chk("async_reset_ss", tod(0), 32'h0);
    chk("async_reset_pulses", pulses(0), 32'h0);
    reset = 1'b0;
    tk();
    chk("tick_after_reset", tod(0), 32'h000001);

    // prescaler on the 4 ticks/s instance
    reset = 1'b1; #1 reset = 1'b0;
    idle();
    sec_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tk();
      if (sec_o[1]) sec_cnt++;
      if (i == 3 || i == 7) chk("presc_align", 32'(sec_o[1]), 32'h1);
      idle(); if (sec_o[1]) sec_cnt++;
      idle(); if (sec_o[1]) sec_cnt++;
    end
    chk("presc_sec_count", 32'(sec_cnt), 32'd2);
    chk("presc_ss", tod(1), 32'h000002);

    // full rollover, 24h
    ld(8'h23, 8'h59, 8'h58);
    chk("load_ack_23", 32'(ack_o[0]), 32'h1);
    chk("load_err_h12", 32'(err_o[2]), 32'h1);
    tk();
    chk("pre_rollover", tod(0), 32'h235959);
    tk();
    chk("rollover_time", tod(0), 32'h000000);
    chk("rollover_pulses", pulses(0), 32'h7);
    idle();
    chk("rollover_one_cycle", pulses(0), 32'h0);

    // full rollover, 12h
    ld(8'h11, 8'h59, 8'h59);
    chk("load_ack_h12", 32'(ack_o[2]), 32'h1);
    tk();
    chk("h12_rollover_time", tod(2), 32'h000000);
    chk("h12_rollover_pulses", pulses(2), 32'h7);

    // load check (dut0 now at 12:00:00)
    ld(8'h12, 8'h60, 8'h00);
    chk("err_mm60", {30'd0, ack_o[0], err_o[0]}, 32'h1);
    chk("err_time_kept", tod(0), 32'h120000);
    ld(8'h00, 8'h1A, 8'h00);
    chk("err_nibble", {30'd0, ack_o[0], err_o[0]}, 32'h1);
    ld(8'h09, 8'h30, 8'h15);
    chk("ack_093015", {30'd0, ack_o[0], err_o[0]}, 32'h2);
    chk("time_093015", tod(0), 32'h093015);

    // load beats a simultaneous tick
    step(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h10);
    chk("prio_ss", tod(1), 32'h000010);
    chk("prio_no_sec", 32'(sec_o[1]), 32'h0);
    repeat (3) tk();
    chk("prio_presc_hold", tod(1), 32'h000010);
    tk();
    chk("prio_presc_fourth", tod(1), 32'h000011);

    // pause
    acc = 32'h0;
    repeat (10) begin
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      acc = acc | pulses(0) | pulses(1);
    end
    chk("pause_time", tod(0), 32'h000014);
    chk("pause_pulses", acc, 32'h0);
    tk();
    chk("resume_tick", tod(0), 32'h000015);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] h, m, s;
      if ($urandom_range(0, 1) == 1) begin
        h = bcd($urandom_range(0, 23));
        m = bcd($urandom_range(0, 59));
        s = bcd($urandom_range(0, 59));
      end else begin
        h = 8'($urandom); m = 8'($urandom); s = 8'($urandom);
      end
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) != 0),
           1'($urandom_range(0, 31) == 0), h, m, s);
    end
    repeat (3) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
